// File: rtl/tft_rd_scheduler_if.sv
// -----------------------------------------------------------------------------
// tft_rd_scheduler_if
// Purpose : bundles the frame-sync, pixel-request and memory-read signals of
//           the TFT read scheduler so the block and its neighbours connect
//           through one port.
// Signals :
//   frame_start  1   vertical-sync pulse (one cycle)
//   TFT_req      1   display controller pixel request, one word per cycle
//   TFT_din      16  pixel returned the cycle after TFT_req
//   rd_req       1   memory burst read request
//   rd_addr      24  burst start word address
//   rd_ack       1   memory accepted the pending burst
//   rd_vld       1   read data word valid
//   rd_data      16  read data word
//   underflow    1   sticky: pixel requested while the FIFO was empty
// Modports: slave  = the scheduler itself
//           master = the environment (display controller + memory)
// -----------------------------------------------------------------------------
interface tft_rd_scheduler_if;
    logic        frame_start;
    logic        TFT_req;
    logic [15:0] TFT_din;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic        underflow;

    modport slave (
        input  frame_start,
        input  TFT_req,
        input  rd_ack,
        input  rd_vld,
        input  rd_data,
        output TFT_din,
        output rd_req,
        output rd_addr,
        output underflow
    );

    modport master (
        output frame_start,
        output TFT_req,
        output rd_ack,
        output rd_vld,
        output rd_data,
        input  TFT_din,
        input  rd_req,
        input  rd_addr,
        input  underflow
    );
endinterface

// File: rtl/tft_rd_scheduler.sv
// -----------------------------------------------------------------------------
// tft_rd_scheduler
// Purpose : fetches one frame of pixels from a word-addressed frame buffer in
//           fixed-length bursts and streams them to a TFT controller through
//           a pixel FIFO. Bursts are only issued when the FIFO is guaranteed
//           room for the whole burst (FIFO occupancy + words still in flight).
// Ports   :
//   clk   1   pixel clock
//   rst   1   asynchronous active-high reset
//   bus   tft_rd_scheduler_if.slave (frame_start, TFT_req/TFT_din,
//             rd_req/rd_addr/rd_ack, rd_vld/rd_data, underflow)
// -----------------------------------------------------------------------------
module tft_rd_scheduler #(
    parameter int          H_DISP     = 480,
    parameter int          V_DISP     = 272,
    parameter int          BURST_LEN  = 32,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
    input  logic                 clk,
    input  logic                 rst,
    tft_rd_scheduler_if.slave    bus
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;                 // holds 0..FIFO_DEPTH
    localparam int TOTAL = H_DISP * V_DISP;
    localparam int WW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW:0]   BURST_X = (CW + 1)'(BURST_LEN);
    localparam logic [WW-1:0] TOTAL_W = WW'(TOTAL);
    localparam logic [WW-1:0] BURST_W = WW'(BURST_LEN);
    localparam logic [23:0]   BURST_A = 24'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RECV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     addr_q, addr_d;
    logic [CW-1:0]   out_q, out_d;          // words requested but not yet received
    logic [WW-1:0]   words_q, words_d;      // words requested so far this frame
    logic            discard_q, discard_d;  // in-flight words belong to a flushed frame
    logic            active_q, active_d;    // a frame_start has been seen since reset
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            underflow_q, underflow_d;
    logic [15:0]     tft_din_q;

    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            flush;
    logic            vld_take;
    logic            push;
    logic            pop;
    logic [CW:0]     used;
    logic            credit_ok;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_d       = out_q;
        words_d     = words_q;
        discard_d   = discard_q;
        active_d    = active_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;

        flush    = bus.frame_start;
        // A word is consumed from the memory whenever one is owed, even if it
        // is discarded, so the in-flight count always drains back to zero.
        vld_take = (state_q == S_RECV) && bus.rd_vld && (out_q != '0);
        push     = vld_take && !discard_q && !flush && (count_q != DEPTH_C);
        pop      = bus.TFT_req && (count_q != '0) && !flush;

        used      = {1'b0, count_q} + {1'b0, out_q};
        credit_ok = (used + BURST_X) <= DEPTH_X;

        // Pixel FIFO bookkeeping
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + ONE_C;
            end else if (pop && !push) begin
                count_d = count_q - ONE_C;
            end
        end

        if (flush) begin
            underflow_d = 1'b0;
        end else if (bus.TFT_req && (count_q == '0)) begin
            underflow_d = 1'b1;
        end

        // Every frame_start restarts address and word count for the new frame.
        if (flush) begin
            addr_d   = BASE_ADDR;
            words_d  = '0;
            active_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!flush && active_q) begin
                    if (words_q == TOTAL_W) begin
                        state_d = S_DONE;
                    end else if (credit_ok) begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (bus.rd_ack) begin
                    // The burst is committed; if the frame restarts on this
                    // same cycle its words are still owed and must be drained.
                    out_d   = out_q + BURST_C;
                    state_d = S_RECV;
                    if (flush) begin
                        discard_d = 1'b1;
                    end else begin
                        words_d = words_q + BURST_W;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end

            S_RECV: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (vld_take) begin
                    out_d = out_q - ONE_C;
                    if (out_q == ONE_C) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                        if (!discard_q && !flush) begin
                            addr_d = addr_q + BURST_A;
                        end
                    end
                end
            end

            S_DONE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE_ADDR;
            out_q       <= '0;
            words_q     <= '0;
            discard_q   <= 1'b0;
            active_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            tft_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            words_q     <= words_d;
            discard_q   <= discard_d;
            active_q    <= active_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            // Registered read: head word appears the cycle after the pop.
            tft_din_q   <= pop ? mem_q[rd_ptr_q] : 16'h0000;
        end
    end

    // FIFO storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rd_data;
        end
    end

    assign bus.rd_req    = (state_q == S_ISSUE);
    assign bus.rd_addr   = addr_q;
    assign bus.TFT_din   = tft_din_q;
    assign bus.underflow = underflow_q;

endmodule

// File: doc/tft_rd_scheduler.md
TFT_RD_SCHEDULER -- requirements
Module: tft_rd_scheduler

Interface
REQ-001 Parameter H_DISP, 480, active pixels per line.
REQ-002 Parameter V_DISP, 272, active lines per frame.
REQ-003 Parameter BURST_LEN, 32, words per memory read burst; H_DISP*V_DISP SHALL be an integer multiple of BURST_LEN.
REQ-004 Parameter FIFO_DEPTH, 64, pixel FIFO depth in words; a power of two and at least 2*BURST_LEN.
REQ-005 Parameter BASE_ADDR, 24'h000000, frame buffer start word address.
REQ-006 clk  input  1  system clock, 10 MHz pixel clock.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 frame_start  input  1  single-cycle pulse at the start of each frame's vertical sync.
REQ-009 TFT_req  input  1  pixel request from the display controller; one word per high cycle.
REQ-010 TFT_din  output  16  pixel returned in the cycle after TFT_req.
REQ-011 rd_req  output  1  memory burst read request.
REQ-012 rd_addr  output  24  burst start word address.
REQ-013 rd_ack  input  1  memory accepts the pending burst.
REQ-014 rd_vld  input  1  read data word valid.
REQ-015 rd_data  input  16  read data word.
REQ-016 underflow  output  1  sticky flag: a TFT_req arrived while the FIFO was empty.

Function
REQ-017 The block SHALL be a one-clock design: a pixel FIFO plus a burst-issue FSM with states IDLE, ISSUE, RECV and DONE.
REQ-018 Credit rule: free = FIFO_DEPTH - fifo_count - outstanding words; a burst is issued only when free >= BURST_LEN.
REQ-019 IDLE -> ISSUE when the credit rule holds and the frame is not fully fetched; IDLE -> DONE when all H_DISP*V_DISP words have been requested.
REQ-020 In ISSUE, rd_req and rd_addr SHALL stay stable until rd_ack; on the ack cycle rd_req drops, outstanding += BURST_LEN, and the FSM moves to RECV.
REQ-021 In RECV, each rd_vld writes rd_data to the FIFO and decrements outstanding; when outstanding reaches 0 the FSM returns to IDLE and rd_addr advances by BURST_LEN.
REQ-022 In DONE, the block SHALL issue no further bursts until frame_start.
REQ-023 TFT_din SHALL be registered: the FIFO head is popped on a TFT_req cycle and presented on TFT_din exactly one cycle later; 16'h0000 is presented when no pop occurred.
REQ-024 A simultaneous pop and push SHALL leave fifo_count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 TFT_req with the FIFO empty SHALL pop nothing, drive TFT_din = 0 on the next cycle, and set underflow.
REQ-026 rd_vld arriving with the FIFO full is excluded by the credit rule; a push on a full FIFO SHALL be dropped, never overwrite stored data.
REQ-027 frame_start in IDLE or DONE SHALL flush the FIFO, reset rd_addr to BASE_ADDR, clear underflow, and enter IDLE in the next cycle.
REQ-028 frame_start in ISSUE before rd_ack SHALL drop rd_req and apply the flush of REQ-027 immediately.
REQ-029 frame_start in ISSUE on the rd_ack cycle, or in RECV, SHALL flush the FIFO and reset rd_addr, then receive and discard the remaining outstanding words before returning to IDLE.
REQ-030 The frame word counter SHALL wrap to 0 on frame_start; a new frame's fetch SHALL start from BASE_ADDR.

Reset
REQ-031 While rst is high: state=IDLE, rd_req=0, rd_addr=BASE_ADDR, TFT_din=0, underflow=0, FIFO empty, outstanding=0.
REQ-032 Reset SHALL take effect asynchronously at any point, including mid-burst; data that arrives later is discarded until the first new burst is acked.

Verification
REQ-033 After reset, frame_start pulse -> rd_req=1 with rd_addr=0x000000; ack; 32 rd_vld words -> second burst at 0x000020; no third burst until the FIFO drains (64-word depth).
REQ-034 FIFO holding words 0xA001, 0xA002; TFT_req high for 2 cycles -> TFT_din = 0xA001 then 0xA002, each one cycle after its request.
REQ-035 FIFO empty, TFT_req=1 -> TFT_din=0 next cycle and underflow=1; next frame_start -> underflow=0.
REQ-036 Full frame at 480x272 with zero-wait memory and continuous TFT_req during active lines -> 4080 bursts, last rd_addr=0x01FDE0, then DONE with no further rd_req.
REQ-037 frame_start after 10 of 32 words of a burst -> remaining 22 words discarded, FIFO empty, next rd_req at 0x000000.
REQ-038 rst asserted in RECV -> all outputs at reset values within the same cycle.
